// File: rtl/dac_26x4_pkg.sv
// Shared constants and FSM state encoding for the LTC26x4-family SPI write engine.
package dac_26x4_pkg;

  localparam int unsigned FRAME_W = 32;

  localparam logic [3:0] CMD_WR         = 4'b0000;
  localparam logic [3:0] CMD_UPD        = 4'b0001;
  localparam logic [3:0] CMD_WR_UPD_ALL = 4'b0010;
  localparam logic [3:0] CMD_WR_UPD     = 4'b0011;
  localparam logic [3:0] CMD_PWRDN      = 4'b0100;
  localparam logic [3:0] CMD_NOP        = 4'b1111;
  localparam logic [3:0] ADDR_ALL       = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_CSHI,
    ST_CLR_PULSE
  } state_t;

endpackage

// File: rtl/dac_spi_shift32.sv
// SCK divider and 32-bit TX/RX shift path; sequenced by the state of the owning FSM.
module dac_spi_shift32
  import dac_26x4_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  state_t             i_state,
  input  logic               i_load,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic               i_miso,
  output logic               o_sck,
  output logic               o_mosi,
  output logic [FRAME_W-1:0] o_rx_word,
  output logic               o_phase_end
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]   r_div;
  logic [4:0]         r_bit;
  logic               r_sck;
  logic [FRAME_W-1:0] r_tx;
  logic [FRAME_W-1:0] r_rx;
  logic               w_div_last;

  assign w_div_last = (r_div == DIV_W'(CLK_DIV - 1));

  always_comb begin
    o_phase_end = 1'b0;
    case (i_state)
      ST_SETUP: o_phase_end = w_div_last;
      ST_SHIFT: o_phase_end = w_div_last && r_sck && (r_bit == 5'd31);
      ST_HOLD:  o_phase_end = w_div_last;
      default:  o_phase_end = 1'b0;
    endcase
  end

  // sck toggles every CLK_DIV cycles; rising half samples MISO, falling half advances MOSI
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_bit <= '0;
      r_sck <= 1'b0;
      r_tx  <= '0;
      r_rx  <= '0;
    end else if (i_load) begin
      r_div <= '0;
      r_bit <= '0;
      r_sck <= 1'b0;
      r_tx  <= i_frame;
    end else begin
      case (i_state)
        ST_SETUP, ST_HOLD: r_div <= w_div_last ? '0 : r_div + 1'b1;
        ST_SHIFT: begin
          if (w_div_last) begin
            r_div <= '0;
            r_sck <= ~r_sck;
            if (!r_sck) begin
              r_rx <= {r_rx[FRAME_W-2:0], i_miso};
            end else begin
              r_tx  <= {r_tx[FRAME_W-2:0], 1'b0};
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: begin
          r_div <= '0;
          r_sck <= 1'b0;
        end
      endcase
    end
  end

  assign o_sck     = r_sck;
  assign o_mosi    = r_tx[FRAME_W-1];
  assign o_rx_word = r_rx;

endmodule

// File: rtl/dac_26x4_mch.sv
// LTC2604/2614/2624 quad-DAC SPI write engine: command port, idle-time channel refresh, CLR pulse.
module dac_26x4_mch
  import dac_26x4_pkg::*;
#(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned CS_HIGH_CYC = 2,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CLR_CYC     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [3:0]             s_cmd,
  input  logic [3:0]             s_addr,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   scan_en,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic                   clr_req,
  output logic                   spi_sck,
  output logic                   spi_mosi,
  input  logic                   spi_miso,
  output logic                   dac_cs_n,
  output logic                   dac_clr_n,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_W-1:0]     rx_word
);

  state_t             r_state, w_state_nxt;
  logic               r_live;
  logic               r_clr_pend;
  logic               r_is_scan;
  logic               r_frame_done;
  logic [1:0]         r_scan_idx;
  logic [15:0]        r_cnt;
  logic               w_launch, w_launch_scan, w_go_clr, w_phase_end;
  logic [3:0]         w_cmd, w_addr;
  logic [DATA_W-1:0]  w_data;
  logic [15:0]        w_dfield;
  logic [FRAME_W-1:0] w_frame;

  // r_live keeps s_ready low while reset is asserted even though the FSM sits in IDLE
  assign s_ready = r_live && (r_state == ST_IDLE) && !r_clr_pend;

  always_comb begin
    w_state_nxt   = r_state;
    w_launch      = 1'b0;
    w_launch_scan = 1'b0;
    w_go_clr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_clr_pend) begin
          w_go_clr    = 1'b1;
          w_state_nxt = ST_CLR_PULSE;
        end else if (s_valid && s_ready) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_SETUP;
        end else if (scan_en && r_live) begin
          w_launch      = 1'b1;
          w_launch_scan = 1'b1;
          w_state_nxt   = ST_SETUP;
        end
      end
      ST_SETUP:     if (w_phase_end) w_state_nxt = ST_SHIFT;
      ST_SHIFT:     if (w_phase_end) w_state_nxt = ST_HOLD;
      ST_HOLD:      if (w_phase_end) w_state_nxt = ST_CSHI;
      ST_CSHI:      if (r_cnt == 16'(CS_HIGH_CYC - 1)) w_state_nxt = ST_IDLE;
      ST_CLR_PULSE: if (r_cnt == 16'(CLR_CYC - 1)) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_cmd    = w_launch_scan ? CMD_WR_UPD : s_cmd;
  assign w_addr   = w_launch_scan ? {2'b00, r_scan_idx} : s_addr;
  assign w_data   = w_launch_scan ? ch_data[32'(r_scan_idx) * DATA_W +: DATA_W] : s_data;
  assign w_dfield = 16'(w_data) << (16 - DATA_W);
  assign w_frame  = {8'h00, w_cmd, w_addr, w_dfield};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_live       <= 1'b0;
      r_clr_pend   <= 1'b0;
      r_is_scan    <= 1'b0;
      r_frame_done <= 1'b0;
      r_scan_idx   <= '0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_live       <= 1'b1;
      r_clr_pend   <= (r_clr_pend | clr_req) & ~w_go_clr;
      r_frame_done <= (r_state == ST_HOLD) && w_phase_end;
      r_cnt        <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
      if (w_launch) r_is_scan <= w_launch_scan;
      if ((r_state == ST_HOLD) && w_phase_end && r_is_scan)
        r_scan_idx <= (r_scan_idx == 2'(N_CH - 1)) ? '0 : r_scan_idx + 1'b1;
    end
  end

  dac_spi_shift32 #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_state    (r_state),
    .i_load     (w_launch),
    .i_frame    (w_frame),
    .i_miso     (spi_miso),
    .o_sck      (spi_sck),
    .o_mosi     (spi_mosi),
    .o_rx_word  (rx_word),
    .o_phase_end(w_phase_end)
  );

  assign dac_cs_n   = !((r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD));
  assign dac_clr_n  = (r_state != ST_CLR_PULSE);
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_dac_26x4_mch.sv
// Scoreboard bench: stimulus queues expected MOSI words, a monitor rebuilds frames from the pins.
module tb_dac_26x4_mch;

  localparam int unsigned CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0, s_ready;
  logic [3:0]  s_cmd = '0, s_addr = '0;
  logic [11:0] s_data = '0;
  logic        scan_en = 1'b0;
  logic [47:0] ch_data = '0;
  logic        clr_req = 1'b0;
  logic        spi_sck, spi_mosi, spi_miso = 1'b0;
  logic        dac_cs_n, dac_clr_n, busy, frame_done;
  logic [31:0] rx_word;

  logic        v16 = 1'b0, rdy16, sck16, mosi16, cs16, clrn16, busy16, fd16;
  logic [31:0] rx16;
  logic        v14 = 1'b0, rdy14, sck14, mosi14, cs14, clrn14, busy14, fd14;
  logic [31:0] rx14;

  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sdo_word = 32'hDEAD_BEEF;
  int          fd_cnt = 0, clr_pulses = 0, rises = 0;
  int          done16 = 0, done14 = 0, nfd16 = 0, nfd14 = 0;

  always #5 clk = ~clk;

  dac_26x4_mch #(.DATA_W(12), .CLK_DIV(CLK_DIV), .CS_HIGH_CYC(2), .N_CH(4), .CLR_CYC(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_cmd(s_cmd),
    .s_addr(s_addr), .s_data(s_data), .scan_en(scan_en), .ch_data(ch_data),
    .clr_req(clr_req), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .dac_cs_n(dac_cs_n), .dac_clr_n(dac_clr_n), .busy(busy), .frame_done(frame_done),
    .rx_word(rx_word));

  dac_26x4_mch #(.DATA_W(16), .CLK_DIV(1), .CS_HIGH_CYC(2), .N_CH(1), .CLR_CYC(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .s_valid(v16), .s_ready(rdy16), .s_cmd(4'h3),
    .s_addr(4'hF), .s_data(16'h8001), .scan_en(1'b0), .ch_data(16'h0000),
    .clr_req(1'b0), .spi_sck(sck16), .spi_mosi(mosi16), .spi_miso(1'b0),
    .dac_cs_n(cs16), .dac_clr_n(clrn16), .busy(busy16), .frame_done(fd16), .rx_word(rx16));

  dac_26x4_mch #(.DATA_W(14), .CLK_DIV(3), .CS_HIGH_CYC(2), .N_CH(4), .CLR_CYC(4)) u_dut14 (
    .clk(clk), .rst_n(rst_n), .s_valid(v14), .s_ready(rdy14), .s_cmd(4'h3),
    .s_addr(4'h0), .s_data(14'h3FFF), .scan_en(1'b0), .ch_data(56'h0),
    .clr_req(1'b0), .spi_sck(sck14), .spi_mosi(mosi14), .spi_miso(1'b0),
    .dac_cs_n(cs14), .dac_clr_n(clrn14), .busy(busy14), .frame_done(fd14), .rx_word(rx14));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
  endtask

  // DAC SDO model: first bit when CS falls, next bit after each SCK falling edge
  initial begin : miso_drv
    logic pcs, psck;
    int   bi;
    pcs = 1'b1; psck = 1'b0; bi = 0;
    forever begin
      @(negedge clk);
      if (!dac_cs_n && pcs) begin
        bi = 31; spi_miso = sdo_word[bi];
      end else if (!dac_cs_n && psck && !spi_sck && bi > 0) begin
        bi = bi - 1; spi_miso = sdo_word[bi];
      end
      pcs = dac_cs_n; psck = spi_sck;
    end
  end

  // Monitor for the main instance
  logic        prev_cs = 1'b1, prev_sck = 1'b0, gap_ok = 1'b0;
  logic [31:0] cap = '0, e;
  int          cs_len = 0, hi_len = 0, clr_len = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cs = 1'b1; prev_sck = 1'b0; gap_ok = 1'b0;
      cap = '0; rises = 0; cs_len = 0; hi_len = 0; clr_len = 0;
    end else begin
      if (spi_sck && !prev_sck) begin
        cap = {cap[30:0], spi_mosi};
        rises++;
      end
      if (!dac_cs_n) begin
        if (prev_cs) begin
          if (gap_ok) chk("cs_high_gap_ge2", 32'(hi_len >= 2), 32'd1);
          cs_len = 0;
        end
        cs_len++;
      end else begin
        if (!prev_cs) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_frame: got %h required no frame", cap);
          end else begin
            e = exp_q.pop_front();
            chk("mosi_word", cap, e);
            chk("sck_rises", 32'(rises), 32'd32);
            chk("cs_low_cycles", 32'(cs_len), 32'(66 * CLK_DIV));
          end
          gap_ok = 1'b1; hi_len = 0; cap = '0; rises = 0;
        end
        hi_len++;
      end
      if (frame_done) begin
        fd_cnt++;
        chk("rx_word", rx_word, sdo_word);
        chk("cs_high_at_done", 32'(dac_cs_n), 32'd1);
      end
      if (!dac_clr_n) clr_len++;
      else if (clr_len != 0) begin
        chk("clr_low_cycles", 32'(clr_len), 32'd4);
        clr_pulses++;
        clr_len = 0;
      end
      prev_cs = dac_cs_n; prev_sck = spi_sck;
    end
  end

  // Monitors for the 16-bit and 14-bit instances
  logic        p16 = 1'b1, ps16 = 1'b0, p14 = 1'b1, ps14 = 1'b0;
  logic [31:0] c16 = '0, c14 = '0;
  int          l16 = 0, l14 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p16 = 1'b1; ps16 = 1'b0; c16 = '0; l16 = 0;
      p14 = 1'b1; ps14 = 1'b0; c14 = '0; l14 = 0;
    end else begin
      if (sck16 && !ps16) c16 = {c16[30:0], mosi16};
      if (!cs16) l16++;
      else if (!p16) begin
        chk("w16_word", c16, 32'h003F_8001);
        chk("w16_cs_low", 32'(l16), 32'd66);
        chk("w16_rx", rx16, 32'h0);
        done16++; c16 = '0; l16 = 0;
      end
      if (fd16) nfd16++;
      if (sck14 && !ps14) c14 = {c14[30:0], mosi14};
      if (!cs14) l14++;
      else if (!p14) begin
        chk("w14_word", c14, 32'h0030_FFFC);
        chk("w14_low_nibble", {28'h0, c14[3:0]}, 32'hC);
        chk("w14_cs_low", 32'(l14), 32'd198);
        done14++; c14 = '0; l14 = 0;
      end
      if (fd14) nfd14++;
      p16 = cs16; ps16 = sck16; p14 = cs14; ps14 = sck14;
    end
  end

  task automatic send(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d, input logic scan);
    int k;
    @(negedge clk);
    s_cmd = c; s_addr = a; s_data = d; s_valid = 1'b1; scan_en = scan;
    for (k = 0; k < 3000 && !s_ready; k++) @(negedge clk);
    chk("accept", 32'(s_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back({8'h00, c, a, d, 4'h0});
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_fd(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < 5000 && seen < n; i++) begin
      @(negedge clk);
      if (frame_done) seen++;
    end
    chk("wait_frame_done", 32'(seen), 32'(n));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got running required finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    ch_data = {12'h444, 12'h333, 12'h222, 12'h111};
    repeat (2) @(negedge clk);
    chk("rst_cs_n", 32'(dac_cs_n), 32'd1);
    chk("rst_sck", 32'(spi_sck), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_clr_n", 32'(dac_clr_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_rx_word", rx_word, 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    rst_n = 1'b1;

    // Width variants run alongside the main instance
    @(negedge clk);
    chk("rdy16", 32'(rdy16), 32'd1);
    chk("rdy14", 32'(rdy14), 32'd1);
    v16 = 1'b1; v14 = 1'b1;
    @(posedge clk);
    #1 v16 = 1'b0; v14 = 1'b0;

    // Single command frame
    send(4'h3, 4'h1, 12'hABC, 1'b0);
    wait_idle();

    // Refresh scan of four channels, disabled during the fifth frame
    exp_q.push_back(32'h0030_1110);
    exp_q.push_back(32'h0031_2220);
    exp_q.push_back(32'h0032_3330);
    exp_q.push_back(32'h0033_4440);
    exp_q.push_back(32'h0030_1110);
    @(negedge clk);
    scan_en = 1'b1;
    wait_fd(4);
    repeat (10) @(negedge clk);
    chk("scan5_in_flight", 32'(busy), 32'd1);
    scan_en = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("scan_stopped", 32'(busy), 32'd0);

    // Command colliding with a scan launch: command first, scan index unchanged
    send(4'h0, 4'h2, 12'h5A5, 1'b1);
    exp_q.push_back(32'h0031_2220);
    wait_fd(1);
    repeat (10) @(negedge clk);
    scan_en = 1'b0;
    wait_idle();

    // CLR requested twice mid-frame: frame intact, one merged pulse afterwards
    send(4'h1, 4'h3, 12'h0F0, 1'b0);
    repeat (40) @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk) clr_req = 1'b0;
    repeat (20) @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk) clr_req = 1'b0;
    wait_fd(1);
    @(negedge clk);
    @(negedge clk);
    chk("clr_pend_s_ready", 32'(s_ready), 32'd0);
    chk("clr_pend_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("clr_active", 32'(dac_clr_n), 32'd0);
    chk("clr_busy", 32'(busy), 32'd1);
    wait_idle();

    // Reset during bit 10: pins idle at once, no frame_done
    send(4'h0, 4'h2, 12'h123, 1'b0);
    for (int i = 0; i < 3000 && rises < 10; i++) @(negedge clk);
    chk("abort_point", 32'(rises), 32'd10);
    void'(exp_q.pop_back());
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(dac_cs_n), 32'd1);
    chk("abort_sck", 32'(spi_sck), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rx", rx_word, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Recovery frame, then a scan frame that must start again at channel 0
    send(4'h4, 4'hF, 12'h000, 1'b0);
    wait_idle();
    exp_q.push_back(32'h0030_1110);
    @(negedge clk);
    scan_en = 1'b1;
    repeat (10) @(negedge clk);
    scan_en = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("frame_done_count", 32'(fd_cnt), 32'd11);
    chk("clr_pulse_count", 32'(clr_pulses), 32'd1);
    chk("w16_frames", 32'(done16), 32'd1);
    chk("w14_frames", 32'(done14), 32'd1);
    chk("w16_done_pulses", 32'(nfd16), 32'd1);
    chk("w14_done_pulses", 32'(nfd14), 32'd1);
    chk("w16_idle", {30'd0, busy16, clrn16}, 32'd1);
    chk("w14_idle", {30'd0, busy14, clrn14}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
